sssp_update_packer: RTL

//  Receiving end of the sssp_pipeline update stream.
//  - Collects the 64-bit update words {weight[63:32], dst[31:0]} from LANES parallel pipelines.
//  - Compacts the valid words and packs them, eight per line, into 512-bit cache lines.
//  - Buffers the lines in a FIFO for the AFU write-back path.
//  - On the pipelines' last_input marker it flushes a padded partial line and signals completion.

---
 rtl/sssp_update_packer_pkg.sv | 26 ++
 rtl/sssp_line_fifo.sv | 56 +++++
 rtl/sssp_update_packer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sssp_update_packer_pkg.sv
// Shared types and constants for the SSSP update packer.
package sssp_update_packer_pkg;

    localparam int unsigned UPDATE_W         = 64;
    localparam int unsigned UPDATES_PER_LINE = 8;
    localparam int unsigned LINE_W           = UPDATE_W * UPDATES_PER_LINE;
    // Slot counter wide enough for held words plus one cycle of new words (max 15).
    localparam int unsigned SLOT_W           = 4;
    localparam int unsigned MERGE_SLOTS      = 16;

    typedef struct packed {
        logic [31:0] weight;
        logic [31:0] dst;
    } update_t;

    // Filler slot: invalid destination, infinite weight.
    localparam update_t UPDATE_PAD = update_t'(64'hFFFF_FFFF_FFFF_FFFF);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } packer_state_e;

endpackage

// File: rtl/sssp_line_fifo.sv
// First-word-fall-through line FIFO; a push while full is honoured only alongside a pop.
module sssp_line_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 512,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    // Head is forced to zero when empty so nothing stale is ever presented.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because the head is gated by empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/sssp_update_packer.sv
// Packs per-lane SSSP update words into 512-bit lines and buffers them for write-back.
module sssp_update_packer
    import sssp_update_packer_pkg::*;
#(
    parameter int unsigned LANES      = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AF_MARGIN  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UPDATE_W*LANES-1:0] upd_in,
    input  logic [LANES-1:0]          upd_valid,
    input  logic                      last_input_in,
    output logic [LINE_W-1:0]         line_out,
    output logic                      line_valid,
    input  logic                      line_ready,
    output logic                      almost_full,
    output logic                      flush_done,
    output logic                      err_overflow,
    output logic                      err_late,
    output logic [31:0]               lines_pushed
);

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned AF_LEVEL = FIFO_DEPTH - AF_MARGIN;

    packer_state_e    state;
    packer_state_e    state_next;
    update_t          acc      [UPDATES_PER_LINE];
    update_t          acc_next [UPDATES_PER_LINE];
    logic [SLOT_W-1:0] acc_cnt;
    logic [SLOT_W-1:0] acc_cnt_next;

    update_t          merged [MERGE_SLOTS];
    logic [SLOT_W-1:0] fill;
    logic [LINE_W-1:0] full_line;
    logic [LINE_W-1:0] pad_line;
    logic [LINE_W-1:0] push_line;
    logic              push;
    logic              late;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop_ok;
    logic              push_ok;
    logic [CNT_W-1:0]  count_next;

    // Compaction: valid lanes land after the held words, each at the running prefix count.
    always_comb begin
        for (int j = 0; j < int'(MERGE_SLOTS); j++) begin
            merged[j] = UPDATE_PAD;
        end
        for (int j = 0; j < int'(UPDATES_PER_LINE); j++) begin
            if (SLOT_W'(j) < acc_cnt) begin
                merged[j] = acc[j];
            end
        end
        fill = acc_cnt;
        for (int i = 0; i < int'(LANES); i++) begin
            if (upd_valid[i]) begin
                merged[fill] = update_t'(upd_in[UPDATE_W*i +: UPDATE_W]);
                fill         = fill + SLOT_W'(1);
            end
        end
    end

    // Candidate lines: first eight merged words, or the held words padded out.
    always_comb begin
        full_line = '0;
        pad_line  = '0;
        for (int s = 0; s < int'(UPDATES_PER_LINE); s++) begin
            full_line[UPDATE_W*s +: UPDATE_W] = merged[s];
            pad_line[UPDATE_W*s +: UPDATE_W]  = (SLOT_W'(s) < acc_cnt) ? acc[s] : UPDATE_PAD;
        end
    end

    // Next-state, accumulator update and push request.
    always_comb begin
        state_next   = state;
        acc_next     = acc;
        acc_cnt_next = acc_cnt;
        push         = 1'b0;
        push_line    = full_line;
        late         = 1'b0;
        unique case (state)
            ST_ACCUM: begin
                if (fill >= SLOT_W'(UPDATES_PER_LINE)) begin
                    push = 1'b1;
                    for (int j = 0; j < int'(UPDATES_PER_LINE); j++) begin
                        acc_next[j] = merged[j + int'(UPDATES_PER_LINE)];
                    end
                    acc_cnt_next = fill - SLOT_W'(UPDATES_PER_LINE);
                end else begin
                    for (int j = 0; j < int'(UPDATES_PER_LINE); j++) begin
                        acc_next[j] = merged[j];
                    end
                    acc_cnt_next = fill;
                end
                if (last_input_in) begin
                    state_next = (acc_cnt_next != '0) ? ST_FLUSH : ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                late         = |upd_valid;
                push         = 1'b1;
                push_line    = pad_line;
                acc_cnt_next = '0;
                state_next   = ST_DRAIN;
            end
            ST_DRAIN: begin
                late = |upd_valid;
                if (fifo_empty) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                late       = |upd_valid;
                state_next = ST_ACCUM;
            end
            default: begin
                state_next = ST_ACCUM;
            end
        endcase
    end

    assign pop_ok     = line_ready & ~fifo_empty;
    assign push_ok    = push & (~fifo_full | pop_ok);
    assign count_next = fifo_count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    assign line_valid = ~fifo_empty;

    // State, accumulator, status flags and push counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_ACCUM;
            acc_cnt      <= '0;
            for (int j = 0; j < int'(UPDATES_PER_LINE); j++) begin
                acc[j] <= UPDATE_PAD;
            end
            almost_full  <= 1'b0;
            flush_done   <= 1'b0;
            err_overflow <= 1'b0;
            err_late     <= 1'b0;
            lines_pushed <= '0;
        end else begin
            state        <= state_next;
            acc_cnt      <= acc_cnt_next;
            acc          <= acc_next;
            almost_full  <= (count_next >= CNT_W'(AF_LEVEL));
            flush_done   <= (state_next == ST_DONE);
            if (push & ~push_ok) begin
                err_overflow <= 1'b1;
            end
            if (late) begin
                err_late <= 1'b1;
            end
            if (push_ok) begin
                lines_pushed <= lines_pushed + 32'd1;
            end
        end
    end

    sssp_line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LINE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_line),
        .pop   (line_ready),
        .dout  (line_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
